// File: rtl/psum_ofifo.sv
// psum_ofifo: per-column output FIFO for a MAC row.
// Each column writes independently, driven by its own valid strobe.
// Reads pop one complete row across all columns.
// The popped row is registered and is marked by a one-cycle o_out_valid pulse.

// ---------------------------------------------------------------------------
// One column lane: circular buffer with write pointer, read pointer and count.
// The pop decision is made at the top level: a row only pops when every lane
// is non-empty. The lane therefore trusts i_pop.
// ---------------------------------------------------------------------------
module psum_ofifo_lane #(
    parameter int psum_bw = 16,
    parameter int depth   = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_wr,
    input  logic               i_pop,
    input  logic [psum_bw-1:0] i_din,
    output logic [psum_bw-1:0] o_head,
    output logic               o_nonempty,
    output logic               o_full,
    output logic               o_drop
);
    localparam int AW = $clog2(depth);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(depth);
    localparam logic [CW-1:0] ONE_C   = CW'(1);
    localparam logic [AW-1:0] PONE_C  = AW'(1);

    logic [psum_bw-1:0] r_mem [depth];
    logic [AW-1:0]      r_wptr;
    logic [AW-1:0]      r_rptr;
    logic [CW-1:0]      r_count;

    logic               w_full;
    logic               w_accept;

    // Flags come from the registered count only.
    // A write to a full lane is still legal when the same edge frees a slot.
    assign w_full     = (r_count == DEPTH_C);
    assign w_accept   = i_wr & (~w_full | i_pop);
    assign o_drop     = i_wr & w_full & ~i_pop;
    assign o_full     = w_full;
    assign o_nonempty = (r_count != '0);
    assign o_head     = r_mem[r_rptr];

    // Pointer and occupancy update. Reset discards any same-cycle write or pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_accept) r_wptr <= r_wptr + PONE_C;
            if (i_pop)    r_rptr <= r_rptr + PONE_C;
            case ({w_accept, i_pop})
                2'b10:   r_count <= r_count + ONE_C;
                2'b01:   r_count <= r_count - ONE_C;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is not cleared by reset; stale entries sit behind an empty count.
    always_ff @(posedge clk) begin
        if (w_accept && !reset) r_mem[r_wptr] <= i_din;
    end
endmodule

// ---------------------------------------------------------------------------
// Top: col lanes, a row-wide pop, the registered output and a sticky overflow.
// ---------------------------------------------------------------------------
module psum_ofifo #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int depth   = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [psum_bw*col-1:0] in,
    input  logic [col-1:0]         wr,
    input  logic                   rd,
    output logic [psum_bw*col-1:0] out,
    output logic                   o_out_valid,
    output logic                   o_valid,
    output logic                   o_full,
    output logic                   o_ready,
    output logic                   o_overflow
);
    logic [col-1:0][psum_bw-1:0] w_head;
    logic [col-1:0]              w_nonempty;
    logic [col-1:0]              w_lane_full;
    logic [col-1:0]              w_drop;
    logic                        w_valid;
    logic                        w_pop;

    logic [psum_bw*col-1:0]      r_out;
    logic                        r_out_valid;
    logic                        r_overflow;

    // A row pop needs every lane populated at the edge.
    // This means there is no fall-through of a same-cycle write.
    assign w_valid = &w_nonempty;
    assign w_pop   = rd & w_valid;

    genvar g;
    generate
        for (g = 0; g < col; g++) begin : g_lane
            psum_ofifo_lane #(
                .psum_bw (psum_bw),
                .depth   (depth)
            ) u_lane (
                .clk        (clk),
                .reset      (reset),
                .i_wr       (wr[g]),
                .i_pop      (w_pop),
                .i_din      (in[g*psum_bw +: psum_bw]),
                .o_head     (w_head[g]),
                .o_nonempty (w_nonempty[g]),
                .o_full     (w_lane_full[g]),
                .o_drop     (w_drop[g])
            );
        end
    endgenerate

    // Registered popped row, its one-cycle strobe, and sticky overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_out_valid <= w_pop;
            if (w_pop)   r_out      <= w_head;
            if (|w_drop) r_overflow <= 1'b1;
        end
    end

    assign out         = r_out;
    assign o_out_valid = r_out_valid;
    assign o_valid     = w_valid;
    assign o_full      = |w_lane_full;
    assign o_ready     = ~(|w_lane_full);
    assign o_overflow  = r_overflow;
endmodule

// File: tb/tb_psum_ofifo.sv
// Scoreboard bench for psum_ofifo.
// The stimulus thread pushes the expected popped rows into a queue.
// A negedge monitor checks every o_out_valid pulse against that queue.
module tb_psum_ofifo;
    localparam int COL = 8;
    localparam int BW  = 16;
    localparam int DEP = 64;
    localparam int W   = COL * BW;

    logic           clk = 1'b0;
    logic           reset;
    logic [W-1:0]   in;
    logic [COL-1:0] wr;
    logic           rd;
    logic [W-1:0]   out;
    logic           o_out_valid, o_valid, o_full, o_ready, o_overflow;

    int n_pass  = 0;
    int n_total = 0;
    logic [W-1:0] sb [$];

    psum_ofifo #(.col(COL), .psum_bw(BW), .depth(DEP)) dut (
        .clk         (clk),
        .reset       (reset),
        .in          (in),
        .wr          (wr),
        .rd          (rd),
        .out         (out),
        .o_out_valid (o_out_valid),
        .o_valid     (o_valid),
        .o_full      (o_full),
        .o_ready     (o_ready),
        .o_overflow  (o_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Build a row with lane i = base + step*k + i.
    function automatic logic [W-1:0] mkrow(input int base, input int step, input int k);
        logic [W-1:0] r;
        for (int i = 0; i < COL; i++) r[i*BW +: BW] = 16'(base + step*k + i);
        return r;
    endfunction

    function automatic logic [W-1:0] fill(input logic [BW-1:0] v);
        logic [W-1:0] r;
        for (int i = 0; i < COL; i++) r[i*BW +: BW] = v;
        return r;
    endfunction

    // Monitor: every output strobe must match the oldest expected row.
    always @(negedge clk) begin
        if (o_out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_pop", out, 'x);
            end else begin
                chk("pop_data", out, sb.pop_front());
            end
        end
    end

    initial begin
        logic [W-1:0] r;
        reset = 1'b1; in = '0; wr = '0; rd = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick();
        chk("rst_valid",   W'(o_valid),     W'(0));
        chk("rst_full",    W'(o_full),      W'(0));
        chk("rst_ready",   W'(o_ready),     W'(1));
        chk("rst_ovf",     W'(o_overflow),  W'(0));
        chk("rst_out",     out,             '0);
        chk("rst_outv",    W'(o_out_valid), W'(0));

        // Three rows in, three rows out, in order.
        for (int k = 0; k < 3; k++) begin
            wr = '1; in = mkrow(0, 16'h0100, k); tick();
        end
        wr = '0;
        for (int k = 0; k < 3; k++) begin
            rd = 1'b1; sb.push_back(mkrow(0, 16'h0100, k)); tick();
        end
        rd = 1'b0; tick();
        chk("basic_empty", W'(o_valid), W'(0));

        // Staggered lanes: a pop is not possible until every lane has data.
        wr = 8'h01; in = '0; in[BW-1:0] = 16'hABCD; tick();
        chk("stag_valid0", W'(o_valid), W'(0));
        wr = 8'hFE; rd = 1'b1; in = mkrow(16'h00E0, 0, 0); tick();
        chk("stag_nopop", W'(o_out_valid), W'(0));
        chk("stag_valid1", W'(o_valid), W'(1));
        wr = '0;
        r = mkrow(16'h00E0, 0, 0); r[BW-1:0] = 16'hABCD;
        sb.push_back(r); tick();
        rd = 1'b0; tick();
        chk("stag_empty", W'(o_valid), W'(0));

        // Fill to depth, overflow, then simultaneous write and pop while full.
        for (int k = 0; k < DEP; k++) begin
            wr = '1; in = mkrow(16'h1000, 16, k); tick();
        end
        chk("full_full",  W'(o_full),     W'(1));
        chk("full_ready", W'(o_ready),    W'(0));
        chk("full_ovf0",  W'(o_overflow), W'(0));
        in = fill(16'hDEAD); tick();
        chk("ovf_set",    W'(o_overflow), W'(1));
        wr = '1; rd = 1'b1; in = fill(16'h5555);
        sb.push_back(mkrow(16'h1000, 16, 0)); tick();
        wr = '0;
        chk("wrpop_full", W'(o_full),     W'(1));
        chk("ovf_sticky", W'(o_overflow), W'(1));
        for (int k = 1; k < DEP; k++) begin
            sb.push_back(mkrow(16'h1000, 16, k)); tick();
        end
        sb.push_back(fill(16'h5555)); tick();
        rd = 1'b0; tick();
        chk("drain_valid", W'(o_valid), W'(0));
        chk("drain_full",  W'(o_full),  W'(0));

        // Streaming through pointer wraps: occupancy never goes above one row.
        for (int n = 0; n <= 200; n++) begin
            wr = (n < 200) ? '1 : '0;
            in = mkrow(16'h2000, 8, n);
            rd = (n > 0);
            if (n > 0) sb.push_back(mkrow(16'h2000, 8, n - 1));
            tick();
            if (n == 0 || n == 100) chk("stream_valid", W'(o_valid), W'(1));
        end
        rd = 1'b0; wr = '0;
        chk("stream_empty", W'(o_valid), W'(0));
        tick();

        // Reset with stored rows and a pending read.
        for (int k = 0; k < 10; k++) begin
            wr = '1; in = mkrow(16'h3000, 8, k); tick();
        end
        reset = 1'b1; rd = 1'b1; wr = '1; tick();
        reset = 1'b0; rd = 1'b0; wr = '0;
        chk("rst2_valid", W'(o_valid),     W'(0));
        chk("rst2_outv",  W'(o_out_valid), W'(0));
        chk("rst2_out",   out,             '0);
        chk("rst2_ovf",   W'(o_overflow),  W'(0));
        chk("rst2_ready", W'(o_ready),     W'(1));
        wr = '1; in = mkrow(16'h4000, 0, 0); tick();
        wr = '0; rd = 1'b1; sb.push_back(mkrow(16'h4000, 0, 0)); tick();
        rd = 1'b0; tick(); tick();

        chk("sb_drained", W'(sb.size()), W'(0));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/psum_ofifo.md
PSUM_OFIFO -- requirements
Module: psum_ofifo

Interface
REQ-001 SHALL have parameter col, default 8, number of columns (one lane per column of the MAC row).
REQ-002 SHALL have parameter psum_bw, default 16, width of one column psum.
REQ-003 SHALL have parameter depth, default 64, entries per lane; power of 2, minimum 2.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port in  input  psum_bw*col  psums; lane i uses bits [psum_bw*(i+1)-1 : psum_bw*i].
REQ-007 SHALL have port wr  input  col  per-lane write strobe; driven by the MAC row valid outputs.
REQ-008 SHALL have port rd  input  1  pop request for one full row (all lanes).
REQ-009 SHALL have port out  output  psum_bw*col  registered popped row, same lane packing as in.
REQ-010 SHALL have port o_out_valid  output  1  one-cycle pulse marking out as newly updated.
REQ-011 SHALL have port o_valid  output  1  every lane non-empty; a pop is possible.
REQ-012 SHALL have port o_full  output  1  at least one lane full.
REQ-013 SHALL have port o_ready  output  1  no lane full; equals ~o_full.
REQ-014 SHALL have port o_overflow  output  1  sticky flag; a write was dropped.

Function
REQ-015 SHALL keep per lane a circular buffer with write pointer, read pointer and occupancy count of width log2(depth)+1.
REQ-016 SHALL derive o_valid, o_full and o_ready combinationally from registered counts only, never from same-cycle inputs.
REQ-017 SHALL accept a write on lane i when wr[i]=1 and the lane is not full: store in slice i at wptr, advance wptr modulo depth.
REQ-018 SHALL accept a write to a full lane when a pop (REQ-019) occurs in the same cycle; the count stays at depth.
REQ-019 SHALL perform a pop when rd=1 and o_valid=1: every lane advances rptr modulo depth and decrements count.
REQ-020 SHALL register out <= head entry of every lane on a pop, with 1-cycle latency; o_out_valid=1 in the following cycle only.
REQ-021 SHALL ignore rd when o_valid=0: no pointer change, out holds its value, o_out_valid=0.
REQ-022 SHALL never pop a lane that is empty at the clock edge, even when the same cycle writes that lane (no fall-through).
REQ-023 SHALL apply a simultaneous accepted write and pop on one lane as both: count unchanged, both pointers advance.
REQ-024 SHALL drop data and set o_overflow=1 when wr[i]=1 with lane i full and no same-cycle pop; that lane's state is unchanged.
REQ-025 SHALL process lanes independently for writes; lanes may hold different counts (staggered column valids).
REQ-026 SHALL hold o_overflow at 1 until reset.
REQ-027 SHALL keep out stable between pops.

Reset
REQ-028 SHALL, when reset=1 at a rising edge, clear all pointers and counts to 0, out to 0, o_out_valid to 0 and o_overflow to 0.
REQ-029 SHALL give reset priority over any same-cycle wr or rd; those requests are discarded.
REQ-030 SHALL not clear storage array contents on reset (contents are unobservable while the lanes are empty).
REQ-031 SHALL drive o_valid=0, o_full=0, o_ready=1 in the cycle after reset.

Verification
REQ-032 SHALL pass this check: after reset, wr=8'hFF for 3 cycles with lane i = 16'h0100*k+i (k=0..2), then rd for 3 cycles -> out rows k=0,1,2 in order, each one cycle after its rd, with o_out_valid pulsing each time.
REQ-033 SHALL pass this check: wr=8'h01 only with lane0=16'hABCD, then rd=1 -> o_valid=0 and no pop; wr=8'hFE next cycle -> o_valid=1 one cycle later; rd -> out lane0=16'hABCD.
REQ-034 SHALL pass this check: fill 64 rows with wr=8'hFF -> o_full=1, o_ready=0; then a 65th write with rd=0 -> o_overflow=1 and the next 64 pops return the first 64 rows unchanged.
REQ-035 SHALL pass this check: lanes full, wr=8'hFF with data 16'h5555 and rd=1 in the same cycle -> no overflow, counts stay 64, and 16'h5555 is returned on the 64th subsequent pop.
REQ-036 SHALL pass this check: write and pop 200 rows continuously with incrementing data, crossing pointer wrap 3 times -> output sequence equals input sequence, and counts never exceed 1 after the first row.
REQ-037 SHALL pass this check: reset asserted with 10 rows stored and rd=1 -> next cycle o_valid=0, o_out_valid=0, out=0, o_overflow=0.
